// File: rtl/ccip_c1_tx_arbiter.sv
// Round-robin arbiter sharing one CCI-P c1 TX write channel between NUM_REQ requesters.
// Each grant is held for a whole batch (req_last, MAX_BATCH beats, or owner idle timeout).
package ccip_c1_arb_pkg;
    typedef struct packed {
        logic [5:0]  rsvd1;
        logic [1:0]  vc_sel;
        logic        sop;
        logic        rsvd2;
        logic [1:0]  cl_len;
        logic [3:0]  req_type;
        logic [5:0]  rsvd3;
        logic [41:0] address;
        logic [15:0] mdata;
    } t_ccip_c1_ReqMemHdr;

    typedef struct packed {
        t_ccip_c1_ReqMemHdr hdr;
        logic [511:0]       data;
        logic               valid;
    } t_if_ccip_c1_Tx;
endpackage

module ccip_c1_tx_arbiter
    import ccip_c1_arb_pkg::*;
#(
    parameter int NUM_REQ      = 2,
    parameter int LMAX_BATCH   = 4,
    parameter int IDLE_TIMEOUT = 16,
    localparam int ID_W        = $clog2(NUM_REQ)
) (
    input  logic                                i_clk,
    input  logic                                i_reset,
    input  logic                                i_enable,
    input  logic [NUM_REQ-1:0]                  i_req_valid,
    input  logic [NUM_REQ-1:0]                  i_req_last,
    input  t_ccip_c1_ReqMemHdr [NUM_REQ-1:0]    i_req_hdr,
    input  logic [NUM_REQ-1:0][511:0]           i_req_data,
    output logic [NUM_REQ-1:0]                  o_req_ready,
    input  logic                                i_sRx_c1TxAlmFull,
    output t_if_ccip_c1_Tx                      o_sTx_c1,
    output logic [ID_W-1:0]                     o_owner_id,
    output logic                                o_busy,
    output logic [31:0]                         o_beats_out,
    output logic [15:0]                         o_batch_splits
);
    localparam int CNT_W  = LMAX_BATCH + 1;
    localparam int IDLE_W = $clog2(IDLE_TIMEOUT + 1);
    localparam logic [ID_W:0]     L_NUM_REQ = (ID_W+1)'(NUM_REQ);
    localparam logic [ID_W:0]     L_ONE     = (ID_W+1)'(1);
    localparam logic [CNT_W-1:0]  L_MAX_M1  = CNT_W'((2**LMAX_BATCH) - 1);
    localparam logic [CNT_W-1:0]  L_CNT_ONE = CNT_W'(1);
    localparam logic [IDLE_W-1:0] L_IDLE_M1 = IDLE_W'(IDLE_TIMEOUT - 1);
    localparam logic [IDLE_W-1:0] L_IDLE_1  = IDLE_W'(1);

    typedef enum logic {S_IDLE, S_GRANT} t_state;

    t_state              r_state, w_state_next;
    logic [ID_W-1:0]     r_rr_ptr, w_rr_ptr_next;
    logic [ID_W-1:0]     r_owner, w_owner_next;
    logic [CNT_W-1:0]    r_beat_cnt, w_beat_cnt_next;
    logic [IDLE_W-1:0]   r_idle_cnt, w_idle_cnt_next;
    t_if_ccip_c1_Tx      r_tx;
    logic [31:0]         r_beats_out;
    logic [15:0]         r_batch_splits;

    logic [2*NUM_REQ-1:0] w_valid_dbl, w_rot;
    logic [ID_W-1:0]      w_off, w_pick, w_owner_inc;
    logic [ID_W:0]        w_sum, w_inc_sum;
    logic                 w_pick_found, w_accept, w_split;
    logic                 w_owner_valid, w_owner_last;

    // Rotate the valid vector so bit 0 is rr_ptr; the lowest set bit is the winner.
    always_comb begin
        w_valid_dbl  = {i_req_valid, i_req_valid};
        w_rot        = w_valid_dbl >> r_rr_ptr;
        w_off        = '0;
        w_pick_found = 1'b0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (w_rot[k]) begin
                w_off        = k[ID_W-1:0];
                w_pick_found = 1'b1;
            end
        end
        w_sum = {1'b0, r_rr_ptr} + {1'b0, w_off};
        if (w_sum >= L_NUM_REQ) begin
            w_sum = w_sum - L_NUM_REQ;
        end
        w_pick = w_sum[ID_W-1:0];

        w_inc_sum = {1'b0, r_owner} + L_ONE;
        w_owner_inc = (w_inc_sum >= L_NUM_REQ) ? '0 : w_inc_sum[ID_W-1:0];
    end

    assign w_owner_valid = i_req_valid[r_owner];
    assign w_owner_last  = i_req_last[r_owner];

    always_comb begin
        w_state_next    = r_state;
        w_owner_next    = r_owner;
        w_rr_ptr_next   = r_rr_ptr;
        w_beat_cnt_next = r_beat_cnt;
        w_idle_cnt_next = r_idle_cnt;
        w_accept        = 1'b0;
        w_split         = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_enable && w_pick_found) begin
                    w_owner_next    = w_pick;
                    w_beat_cnt_next = '0;
                    w_idle_cnt_next = '0;
                    w_state_next    = S_GRANT;
                end
            end
            S_GRANT: begin
                // Almost-full freezes everything, including the idle timer.
                if (!i_sRx_c1TxAlmFull) begin
                    if (w_owner_valid) begin
                        w_accept        = 1'b1;
                        w_beat_cnt_next = r_beat_cnt + L_CNT_ONE;
                        w_idle_cnt_next = '0;
                        if (w_owner_last || (r_beat_cnt == L_MAX_M1)) begin
                            w_state_next  = S_IDLE;
                            w_rr_ptr_next = w_owner_inc;
                            w_split       = !w_owner_last;
                        end
                    end else begin
                        w_idle_cnt_next = r_idle_cnt + L_IDLE_1;
                        if (r_idle_cnt == L_IDLE_M1) begin
                            w_state_next  = S_IDLE;
                            w_rr_ptr_next = w_owner_inc;
                            w_split       = 1'b1;
                        end
                    end
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state        <= S_IDLE;
            r_rr_ptr       <= '0;
            r_owner        <= '0;
            r_beat_cnt     <= '0;
            r_idle_cnt     <= '0;
            r_tx           <= '0;
            r_beats_out    <= '0;
            r_batch_splits <= '0;
        end else begin
            r_state    <= w_state_next;
            r_rr_ptr   <= w_rr_ptr_next;
            r_owner    <= w_owner_next;
            r_beat_cnt <= w_beat_cnt_next;
            r_idle_cnt <= w_idle_cnt_next;
            r_tx.valid <= w_accept;
            if (w_accept) begin
                r_tx.hdr    <= i_req_hdr[r_owner];
                r_tx.data   <= i_req_data[r_owner];
                r_beats_out <= r_beats_out + 32'd1;
            end
            if (w_split && (r_batch_splits != 16'hFFFF)) begin
                r_batch_splits <= r_batch_splits + 16'd1;
            end
        end
    end

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_ready
        assign o_req_ready[gi] = (r_state == S_GRANT) && !i_sRx_c1TxAlmFull
                                 && (r_owner == ID_W'(gi));
    end

    assign o_sTx_c1       = r_tx;
    assign o_owner_id     = r_owner;
    assign o_busy         = (r_state == S_GRANT);
    assign o_beats_out    = r_beats_out;
    assign o_batch_splits = r_batch_splits;
endmodule

// File: tb/tb_ccip_c1_tx_arbiter.sv
// Bench for ccip_c1_tx_arbiter: scripted table, corner-case sequences and
// randomized traffic checked against a cycle-level behavioural model.
module tb_ccip_c1_tx_arbiter;
    import ccip_c1_arb_pkg::*;

    localparam int N       = 2;
    localparam int MAXB    = 16;
    localparam int IDLE_TO = 16;

    logic                         clk = 1'b0;
    logic                         reset;
    logic                         enable;
    logic [N-1:0]                 req_valid, req_last, req_ready;
    t_ccip_c1_ReqMemHdr [N-1:0]   req_hdr;
    logic [N-1:0][511:0]          req_data;
    logic                         alm;
    t_if_ccip_c1_Tx               tx;
    logic [0:0]                   owner_id;
    logic                         busy;
    logic [31:0]                  beats_out;
    logic [15:0]                  batch_splits;

    ccip_c1_tx_arbiter #(.NUM_REQ(N), .LMAX_BATCH(4), .IDLE_TIMEOUT(IDLE_TO)) dut (
        .i_clk(clk), .i_reset(reset), .i_enable(enable),
        .i_req_valid(req_valid), .i_req_last(req_last),
        .i_req_hdr(req_hdr), .i_req_data(req_data),
        .o_req_ready(req_ready), .i_sRx_c1TxAlmFull(alm),
        .o_sTx_c1(tx), .o_owner_id(owner_id), .o_busy(busy),
        .o_beats_out(beats_out), .o_batch_splits(batch_splits)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int hs[N];

    // behavioural model state
    bit                 m_grant;
    int                 m_owner, m_ptr, m_cnt, m_idle, m_splits;
    bit [31:0]          m_beats;
    bit                 m_txv;
    t_ccip_c1_ReqMemHdr m_txh;
    logic [511:0]       m_txd;

    typedef struct {
        logic [1:0] valid;
        logic [1:0] last;
        logic       alm;
        logic [1:0] exp_ready;
        logic       exp_busy;
        logic       exp_owner;
        logic       exp_txv;
        int         exp_beats;
    } vec_t;
    vec_t tbl[12];

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic new_payload();
        for (int i = 0; i < N; i++) begin
            req_hdr[i] = 80'({$urandom(), $urandom(), $urandom()});
            for (int w = 0; w < 16; w++) req_data[i][w*32 +: 32] = $urandom();
        end
    endtask

    task automatic model_reset();
        m_grant = 0; m_owner = 0; m_ptr = 0; m_cnt = 0; m_idle = 0;
        m_splits = 0; m_beats = 0; m_txv = 0; m_txh = '0; m_txd = '0;
    endtask

    task automatic model_release(input bit split);
        m_grant = 0;
        m_ptr = (m_owner + 1) % N;
        if (split && m_splits < 65535) m_splits++;
    endtask

    task automatic model_update();
        bit nxt_txv = 0;
        if (m_grant) begin
            if (!alm) begin
                if (req_valid[m_owner]) begin
                    nxt_txv = 1;
                    m_txh = req_hdr[m_owner];
                    m_txd = req_data[m_owner];
                    m_beats++;
                    m_cnt++;
                    m_idle = 0;
                    if (req_last[m_owner]) model_release(0);
                    else if (m_cnt == MAXB) model_release(1);
                end else begin
                    m_idle++;
                    if (m_idle == IDLE_TO) model_release(1);
                end
            end
        end else if (enable && req_valid != '0) begin
            for (int k = 0; k < N; k++) begin
                int i = (m_ptr + k) % N;
                if (req_valid[i]) begin
                    m_owner = i;
                    break;
                end
            end
            m_grant = 1; m_cnt = 0; m_idle = 0;
        end
        m_txv = nxt_txv;
    endtask

    task automatic check_model();
        logic [N-1:0] er = '0;
        if (m_grant && !alm) er[m_owner] = 1'b1;
        chk("busy", 512'(busy), 512'(m_grant));
        if (m_grant) chk("owner_id", 512'(owner_id), 512'(m_owner));
        chk("req_ready", 512'(req_ready), 512'(er));
        chk("tx_valid", 512'(tx.valid), 512'(m_txv));
        if (m_txv) begin
            chk("tx_hdr", 512'(tx.hdr), 512'(m_txh));
            chk("tx_data", tx.data, m_txd);
        end
        chk("beats_out", 512'(beats_out), 512'(m_beats));
        chk("batch_splits", 512'(batch_splits), 512'(m_splits));
    endtask

    // Called at the falling edge: compare, advance the model, then let the DUT clock.
    task automatic finish_cycle();
        for (int i = 0; i < N; i++) if (req_ready[i] && req_valid[i]) hs[i]++;
        check_model();
        model_update();
        @(posedge clk);
        #1;
    endtask

    task automatic step();
        @(negedge clk);
        finish_cycle();
    endtask

    task automatic drive(input logic [1:0] v, input logic [1:0] l, input logic a);
        req_valid = v; req_last = l; alm = a;
        new_payload();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        model_reset();
        for (int i = 0; i < N; i++) hs[i] = 0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1; enable = 1'b1; req_valid = '0; req_last = '0; alm = 1'b0;
        req_hdr = '0; req_data = '0;

        //            valid  last   alm  ready  busy own txv beats
        tbl[0]  = '{2'b01, 2'b00, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 0};
        tbl[1]  = '{2'b01, 2'b00, 1'b0, 2'b01, 1'b1, 1'b0, 1'b0, 0};
        tbl[2]  = '{2'b01, 2'b00, 1'b0, 2'b01, 1'b1, 1'b0, 1'b1, 1};
        tbl[3]  = '{2'b01, 2'b01, 1'b0, 2'b01, 1'b1, 1'b0, 1'b1, 2};
        tbl[4]  = '{2'b00, 2'b00, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 3};
        tbl[5]  = '{2'b11, 2'b00, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 3};
        tbl[6]  = '{2'b11, 2'b00, 1'b1, 2'b00, 1'b1, 1'b1, 1'b0, 3};
        tbl[7]  = '{2'b11, 2'b00, 1'b0, 2'b10, 1'b1, 1'b1, 1'b0, 3};
        tbl[8]  = '{2'b11, 2'b10, 1'b0, 2'b10, 1'b1, 1'b1, 1'b1, 4};
        tbl[9]  = '{2'b11, 2'b00, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 5};
        tbl[10] = '{2'b01, 2'b01, 1'b0, 2'b01, 1'b1, 1'b0, 1'b0, 5};
        tbl[11] = '{2'b00, 2'b00, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 6};

        do_reset();
        chk("rst_busy", 512'(busy), 512'(0));
        chk("rst_ready", 512'(req_ready), 512'(0));
        chk("rst_tx", 512'(tx.valid), 512'(0));
        chk("rst_owner", 512'(owner_id), 512'(0));
        chk("rst_beats", 512'(beats_out), 512'(0));
        chk("rst_splits", 512'(batch_splits), 512'(0));

        // scripted vectors: 3-beat batch from 0, then 1 with almost-full, then 0 again
        for (int r = 0; r < 12; r++) begin
            drive(tbl[r].valid, tbl[r].last, tbl[r].alm);
            @(negedge clk);
            chk($sformatf("tbl%0d_ready", r), 512'(req_ready), 512'(tbl[r].exp_ready));
            chk($sformatf("tbl%0d_busy", r), 512'(busy), 512'(tbl[r].exp_busy));
            if (tbl[r].exp_busy)
                chk($sformatf("tbl%0d_owner", r), 512'(owner_id), 512'(tbl[r].exp_owner));
            chk($sformatf("tbl%0d_txv", r), 512'(tx.valid), 512'(tbl[r].exp_txv));
            chk($sformatf("tbl%0d_beats", r), 512'(beats_out), 512'(tbl[r].exp_beats));
            finish_cycle();
        end

        // MAX_BATCH split: requester 1 streams without req_last while 0 waits
        do_reset();
        drive(2'b10, 2'b00, 1'b0); step();
        for (int c = 1; c <= 20; c++) begin drive(2'b11, 2'b00, 1'b0); step(); end
        chk("split_hs1", 512'(hs[1]), 512'(16));
        chk("split_hs0", 512'(hs[0]), 512'(3));
        chk("split_cnt", 512'(batch_splits), 512'(1));
        chk("split_owner0", 512'(owner_id), 512'(0));
        drive(2'b11, 2'b01, 1'b0); step();
        drive(2'b11, 2'b00, 1'b0); step();
        chk("resume_busy", 512'(busy), 512'(1));
        chk("resume_owner1", 512'(owner_id), 512'(1));

        // idle timeout: owner 0 stalls while 1 waits
        do_reset();
        drive(2'b01, 2'b00, 1'b0); step();
        drive(2'b01, 2'b00, 1'b0); step();
        drive(2'b01, 2'b00, 1'b0); step();
        for (int c = 1; c <= 15; c++) begin drive(2'b10, 2'b00, 1'b0); step(); end
        chk("to_held", 512'(busy), 512'(1));
        drive(2'b10, 2'b00, 1'b0); step();
        chk("to_released", 512'(busy), 512'(0));
        chk("to_splits", 512'(batch_splits), 512'(1));
        drive(2'b10, 2'b00, 1'b0); step();
        chk("to_owner1", 512'(owner_id), 512'(1));

        // almost-full for 5 cycles mid-batch
        do_reset();
        drive(2'b01, 2'b00, 1'b0); step();
        for (int c = 0; c < 3; c++) begin drive(2'b01, 2'b00, 1'b0); step(); end
        for (int c = 0; c < 5; c++) begin
            drive(2'b01, 2'b00, 1'b1); step();
            chk("af_txv", 512'(tx.valid), 512'(0));
            chk("af_busy", 512'(busy), 512'(1));
        end
        drive(2'b01, 2'b00, 1'b0); step();
        drive(2'b01, 2'b00, 1'b0); step();
        drive(2'b01, 2'b01, 1'b0); step();
        drive(2'b00, 2'b00, 1'b0); step();
        chk("af_beats", 512'(beats_out), 512'(6));
        chk("af_splits", 512'(batch_splits), 512'(0));

        // asynchronous reset during GRANT, then enable held low
        do_reset();
        drive(2'b11, 2'b00, 1'b0); step();
        drive(2'b11, 2'b00, 1'b0); step();
        #2;
        reset = 1'b1; enable = 1'b0;
        #1;
        chk("arst_busy", 512'(busy), 512'(0));
        chk("arst_ready", 512'(req_ready), 512'(0));
        chk("arst_txv", 512'(tx.valid), 512'(0));
        chk("arst_hdr", 512'(tx.hdr), 512'(0));
        chk("arst_data", tx.data, 512'(0));
        chk("arst_beats", 512'(beats_out), 512'(0));
        model_reset();
        @(posedge clk); #1;
        reset = 1'b0;
        for (int c = 0; c < 4; c++) begin
            drive(2'b11, 2'b00, 1'b0); step();
            chk("dis_busy", 512'(busy), 512'(0));
        end
        enable = 1'b1;
        drive(2'b11, 2'b00, 1'b0); step();
        chk("en_busy", 512'(busy), 512'(1));
        chk("en_owner0", 512'(owner_id), 512'(0));

        // randomized traffic against the model
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            int pv;
            case ((c / 200) % 3)
                0:       pv = 90;
                1:       pv = 50;
                default: pv = 5;
            endcase
            for (int i = 0; i < N; i++) begin
                req_valid[i] = ($urandom_range(99) < pv);
                req_last[i]  = ($urandom_range(99) < 20);
            end
            alm    = ($urandom_range(99) < 15);
            enable = ($urandom_range(99) < 90);
            new_payload();
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
